mc_datapath_core: RTL and testbench

- Multi-cycle MIPS datapath stage directly downstream of the multi-cycle controller FSM.
- Consumes the controller's per-state control strobes each cycle.
- Holds the architectural PC and the non-architectural registers (IR, MDR, A, B, ALUOut), and contains the ALU and all datapath muxes.
- Returns opcode/funct/zero to the controller; drives an external unified memory and an external 32x32 register file.

---
 rtl/mc_datapath_core.sv | 177 +++++++++++++++++
 tb/tb_mc_datapath_core.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_core.sv
// ============================================================================
// Module      : mc_datapath_core
// Description : Multi-cycle MIPS datapath: PC, IR/MDR/A/B/ALUOut, ALU and
//               the muxes steered by the multi-cycle controller strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_datapath_core #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    // controller strobes
    input  logic              iord,
    input  logic              mem_to_reg,
    input  logic              reg_dst,
    input  logic [1:0]        pc_src,
    input  logic              alu_src_a,
    input  logic [1:0]        alu_src_b,
    input  logic              ir_write,
    input  logic              mem_write,
    input  logic              pc_write,
    input  logic              branch,
    input  logic              reg_write,
    input  logic [2:0]        alu_control,
    // status back to controller
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic              zero,
    // unified memory
    output logic [WIDTH-1:0]  mem_adr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    // register file
    output logic [4:0]        rf_ra1,
    output logic [4:0]        rf_ra2,
    input  logic [WIDTH-1:0]  rf_rd1,
    input  logic [WIDTH-1:0]  rf_rd2,
    output logic [4:0]        rf_wa,
    output logic [WIDTH-1:0]  rf_wd,
    output logic              rf_we,
    // trace
    output logic [WIDTH-1:0]  pc_q
);

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam logic [WIDTH-1:0] c_four = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;

    logic [WIDTH-1:0] w_signimm;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_alu_result;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pc_en;
    logic             w_slt;

    assign w_signimm = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};

    // ------------------------------------------------------------------
    // Operand muxes
    // ------------------------------------------------------------------
    assign w_src_a = alu_src_a ? r_a : r_pc;

    always_comb begin
        w_src_b = r_b;
        case (alu_src_b)
            2'b00:   w_src_b = r_b;
            2'b01:   w_src_b = c_four;
            2'b10:   w_src_b = w_signimm;
            2'b11:   w_src_b = {w_signimm[WIDTH-3:0], 2'b00};
            default: w_src_b = r_b;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: silent wrap-around, unused encodings yield zero
    // ------------------------------------------------------------------
    assign w_slt = ($signed(w_src_a) < $signed(w_src_b));

    always_comb begin
        w_alu_result = '0;
        case (alu_control)
            c_alu_and: w_alu_result = w_src_a & w_src_b;
            c_alu_or:  w_alu_result = w_src_a | w_src_b;
            c_alu_add: w_alu_result = w_src_a + w_src_b;
            c_alu_sub: w_alu_result = w_src_a - w_src_b;
            c_alu_slt: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
            default:   w_alu_result = '0;
        endcase
    end

    assign zero = (w_alu_result == '0);

    // ------------------------------------------------------------------
    // Next-PC selection; branch resolves against this cycle's zero flag
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_next = r_pc;
        case (pc_src)
            2'b00:   w_pc_next = w_alu_result;
            2'b01:   w_pc_next = r_aluout;
            2'b10:   w_pc_next = {r_pc[WIDTH-1:WIDTH-4], r_ir[25:0], 2'b00};
            2'b11:   w_pc_next = r_pc;
            default: w_pc_next = r_pc;
        endcase
    end

    assign w_pc_en = pc_write | (branch & zero);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= '0;
        end else if (ir_write) begin
            r_ir <= mem_rdata;
        end
    end

    // Non-architectural pipeline latches refresh every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            r_mdr    <= mem_rdata;
            r_a      <= rf_rd1;
            r_b      <= rf_rd2;
            r_aluout <= w_alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; write strobes are blocked while reset is asserted so no
    // partial write escapes an aborted instruction
    // ------------------------------------------------------------------
    assign opcode    = r_ir[31:26];
    assign funct     = r_ir[5:0];
    assign mem_adr   = iord ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = mem_write & ~reset;
    assign rf_ra1    = r_ir[25:21];
    assign rf_ra2    = r_ir[20:16];
    assign rf_wa     = reg_dst ? r_ir[15:11] : r_ir[20:16];
    assign rf_wd     = mem_to_reg ? r_mdr : r_aluout;
    assign rf_we     = reg_write & ~reset;
    assign pc_q      = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_mc_datapath_core.sv
// ============================================================================
// Module      : tb_mc_datapath_core
// Description : Directed scoreboard bench for mc_datapath_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_datapath_core;

    logic        clk;
    logic        reset;
    logic        iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0]  pc_src, alu_src_b;
    logic        ir_write, mem_write, pc_write, branch, reg_write;
    logic [2:0]  alu_control;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] rf_rd1, rf_rd2, rf_wd, pc_q;
    logic        rf_we;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    mc_datapath_core #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iord        (iord),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .reg_write   (reg_write),
        .alu_control (alu_control),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .rf_we       (rf_we),
        .pc_q        (pc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iord        = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        alu_control = 3'b010;
    endtask

    // PC <= A + B with B = 0, A loaded from rf_rd1 one cycle earlier
    task automatic set_pc(input logic [31:0] v);
        idle();
        rf_rd1 = v;
        rf_rd2 = 32'h0;
        tick();
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
        tick();
        idle();
    endtask

    task automatic alu_case(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res);
        idle();
        rf_rd1 = a;
        rf_rd2 = b;
        tick();
        alu_src_a   = 1'b1;
        alu_control = op;
        expect_val({tag, "_zero"}, {31'b0, (res == 32'h0)});
        #1 check(zero);
        expect_val(tag, res);
        tick();
        iord = 1'b1;
        #1 check(mem_adr);
        idle();
    endtask

    initial begin
        reset     = 1'b1;
        idle();
        mem_rdata = 32'h0;
        rf_rd1    = 32'h0;
        rf_rd2    = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Load some in-flight state, then reset mid-cycle
        mem_rdata = 32'hFFFF_FFFF;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        tick();
        expect_val("pre_reset_pc", 32'h104);
        check(pc_q);
        #2 reset = 1'b1;
        #1;
        expect_val("rst_pc", 32'h100);      check(pc_q);
        expect_val("rst_opcode", 32'h0);    check(opcode);
        expect_val("rst_funct", 32'h0);     check(funct);
        expect_val("rst_mem_adr", 32'h100); check(mem_adr);
        tick();
        expect_val("rst_hold_pc", 32'h100); check(pc_q);
        expect_val("rst_hold_ir", 32'h0);   check(opcode);
        reset = 1'b0;
        idle();

        // Fetch
        mem_rdata = 32'h8C82_0004;
        rf_rd1    = 32'h0000_2000;
        rf_rd2    = 32'h1234_5678;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        expect_val("fetch_zero", 32'h0);
        expect_val("fetch_adr", 32'h100);
        #1;
        check(zero);
        check(mem_adr);
        tick();
        expect_val("fetch_opcode", 32'h23);       check(opcode);
        expect_val("fetch_funct", 32'h04);        check(funct);
        expect_val("fetch_pc", 32'h104);          check(pc_q);
        expect_val("fetch_ra1", 32'h4);           check(rf_ra1);
        expect_val("fetch_ra2", 32'h2);           check(rf_ra2);
        expect_val("fetch_wdata", 32'h1234_5678); check(mem_wdata);

        // LW address computation and writeback muxes
        idle();
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        iord = 1'b1;
        expect_val("lw_adr", 32'h2004);
        expect_val("lw_ir_hold", 32'h23);
        #1;
        check(mem_adr);
        check(opcode);
        mem_write = 1'b1;
        expect_val("mem_we", 32'h1);
        #1 check(mem_we);
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        expect_val("lw_wa", 32'h2);
        expect_val("lw_wd", 32'hDEAD_BEEF);
        expect_val("rf_we", 32'h1);
        #1;
        check(rf_wa);
        check(rf_wd);
        check(rf_we);
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
        expect_val("rd_wa", 32'h0);
        expect_val("rd_wd_aluout", 32'h2004);
        #1;
        check(rf_wa);
        check(rf_wd);

        // BEQ taken
        set_pc(32'h40);
        mem_rdata = 32'h1043_0003;
        ir_write  = 1'b1;
        tick();
        expect_val("beq_opcode", 32'h04); check(opcode);
        idle();
        alu_src_b = 2'b11;
        rf_rd1    = 32'd5;
        rf_rd2    = 32'd5;
        tick();
        expect_val("beq_target", 32'h4C);
        iord = 1'b1;
        #1 check(mem_adr);
        idle();
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        branch      = 1'b1;
        pc_src      = 2'b01;
        expect_val("beq_zero_taken", 32'h1);
        #1 check(zero);
        tick();
        expect_val("beq_pc_taken", 32'h4C); check(pc_q);

        // BEQ not taken
        set_pc(32'h40);
        alu_src_b = 2'b11;
        rf_rd1    = 32'd5;
        rf_rd2    = 32'd6;
        tick();
        idle();
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        branch      = 1'b1;
        pc_src      = 2'b01;
        expect_val("beq_zero_not", 32'h0);
        #1 check(zero);
        tick();
        expect_val("beq_pc_not", 32'h40); check(pc_q);

        // pc_write with branch not taken still loads (5 - 6)
        idle();
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        branch      = 1'b1;
        pc_write    = 1'b1;
        tick();
        expect_val("pcw_branch_pc", 32'hFFFF_FFFF); check(pc_q);

        // Unknown selects with all enables low leave state intact
        idle();
        pc_src    = 2'bxx;
        alu_src_b = 2'bxx;
        mem_rdata = 32'h0;
        tick();
        expect_val("x_sel_pc", 32'hFFFF_FFFF); check(pc_q);
        expect_val("x_sel_ir", 32'h04);        check(opcode);

        // Jump
        set_pc(32'h1000_0010);
        mem_rdata = 32'h0800_0040;
        ir_write  = 1'b1;
        tick();
        idle();
        pc_src   = 2'b10;
        pc_write = 1'b1;
        tick();
        expect_val("jump_pc", 32'h1000_0100); check(pc_q);

        // ALU corners
        alu_case("slt_neg",  3'b111, 32'hFFFF_FFFF, 32'h1,          32'h1);
        alu_case("slt_pos",  3'b111, 32'h1,          32'hFFFF_FFFF, 32'h0);
        alu_case("add_wrap", 3'b010, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000);
        alu_case("sub_wrap", 3'b110, 32'h0,          32'h1,          32'hFFFF_FFFF);
        alu_case("and",      3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        alu_case("or",       3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        alu_case("op011",    3'b011, 32'h1234_5678, 32'h1,          32'h0);
        alu_case("op100",    3'b100, 32'h1234_5678, 32'h1,          32'h0);
        alu_case("op101",    3'b101, 32'h1234_5678, 32'h1,          32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
